// File: rtl/sram_like_arbiter_if.sv
// Generic sram-like port: request/address phase plus data phase handshake.
// One instance per master and one for the shared downstream port.
interface sram_like_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addrok;
  logic        dataok;

  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addrok, dataok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addrok, dataok
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one downstream sram-like port between inst-fetch and data masters.
// One transaction in flight; data has priority, bounded by an anti-starvation count.
//
// state | meaning
// IDLE  | no transaction; grant evaluated each cycle
// ADDR  | mem_req high, waiting for mem_addrok
// DATA  | address accepted, waiting for mem_dataok
module sram_like_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  sram_like_if.slave  inst_if,
  sram_like_if.slave  data_if,
  sram_like_if.master mem_if,
  output logic        busy_o,
  output logic        owner_o
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        mem_wr_q, mem_wr_d;
  logic [1:0]  mem_size_q, mem_size_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      starve_cnt_q <= '0;
      mem_wr_q     <= 1'b0;
      mem_size_q   <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      mem_wr_q     <= mem_wr_d;
      mem_size_q   <= mem_size_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    mem_wr_d     = mem_wr_q;
    mem_size_d   = mem_size_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (inst_if.req && (!data_if.req || starve_cnt_q == LIMIT)) begin
          state_d      = ADDR;
          owner_d      = 1'b0;
          starve_cnt_d = '0;
          mem_wr_d     = inst_if.wr;
          mem_size_d   = inst_if.size;
          mem_addr_d   = inst_if.addr;
          mem_wdata_d  = inst_if.wdata;
        end else if (data_if.req) begin
          state_d     = ADDR;
          owner_d     = 1'b1;
          mem_wr_d    = data_if.wr;
          mem_size_d  = data_if.size;
          mem_addr_d  = data_if.addr;
          mem_wdata_d = data_if.wdata;
          // Only count data wins that actually made inst wait.
          if (!inst_if.req)
            starve_cnt_d = '0;
          else if (starve_cnt_q != LIMIT)
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
      end
      ADDR: if (mem_if.addrok) state_d = DATA;
      DATA: if (mem_if.dataok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_if.req     = (state_q == ADDR);
    mem_if.wr      = mem_wr_q;
    mem_if.size    = mem_size_q;
    mem_if.addr    = mem_addr_q;
    mem_if.wdata   = mem_wdata_q;
    inst_if.addrok = (state_q == ADDR) && mem_if.addrok && !owner_q;
    data_if.addrok = (state_q == ADDR) && mem_if.addrok &&  owner_q;
    inst_if.dataok = (state_q == DATA) && mem_if.dataok && !owner_q;
    data_if.dataok = (state_q == DATA) && mem_if.dataok &&  owner_q;
    inst_if.rdata  = mem_if.rdata;
    data_if.rdata  = mem_if.rdata;
    busy_o         = (state_q != IDLE);
    owner_o        = owner_q;
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: per-cycle vector table plus
// hand sequences for starvation, write fields and mid-transaction reset.
module tb_sram_like_arbiter;

  localparam logic [31:0] IADDR = 32'hBFC0_0000;
  localparam logic [31:0] DADDR = 32'h8000_1000;
  localparam logic [31:0] RD1   = 32'h3C1D_0001;
  localparam logic [31:0] RD2   = 32'h1234_5678;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic busy_o, owner_o;

  sram_like_if inst_if ();
  sram_like_if data_if ();
  sram_like_if mem_if ();

  sram_like_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_if(inst_if), .data_if(data_if), .mem_if(mem_if),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        ireq, dreq, aok, dok;
    logic [31:0] rdata;
    logic        e_mreq, e_busy, e_owner, e_iaok, e_idok, e_daok, e_ddok;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vt[19];

  function automatic vec_t mk(input logic ir, dr, ao, dk, input logic [31:0] rd,
                              input logic mr, bz, ow, ia, id, da, dd,
                              input logic [31:0] ad);
    vec_t v;
    v.ireq = ir; v.dreq = dr; v.aok = ao; v.dok = dk; v.rdata = rd;
    v.e_mreq = mr; v.e_busy = bz; v.e_owner = ow;
    v.e_iaok = ia; v.e_idok = id; v.e_daok = da; v.e_ddok = dd; v.e_addr = ad;
    return v;
  endfunction

  task automatic apply_vec(input int i, input string tag);
    @(negedge clk);
    inst_if.req   = vt[i].ireq;
    data_if.req   = vt[i].dreq;
    mem_if.addrok = vt[i].aok;
    mem_if.dataok = vt[i].dok;
    mem_if.rdata  = vt[i].rdata;
    #1;
    chk($sformatf("%s[%0d].mem_req", tag, i), 32'(mem_if.req), 32'(vt[i].e_mreq));
    chk($sformatf("%s[%0d].busy", tag, i), 32'(busy_o), 32'(vt[i].e_busy));
    chk($sformatf("%s[%0d].inst_addrok", tag, i), 32'(inst_if.addrok), 32'(vt[i].e_iaok));
    chk($sformatf("%s[%0d].inst_dataok", tag, i), 32'(inst_if.dataok), 32'(vt[i].e_idok));
    chk($sformatf("%s[%0d].data_addrok", tag, i), 32'(data_if.addrok), 32'(vt[i].e_daok));
    chk($sformatf("%s[%0d].data_dataok", tag, i), 32'(data_if.dataok), 32'(vt[i].e_ddok));
    if (vt[i].e_busy)
      chk($sformatf("%s[%0d].owner", tag, i), 32'(owner_o), 32'(vt[i].e_owner));
    if (vt[i].e_mreq)
      chk($sformatf("%s[%0d].mem_addr", tag, i), mem_if.addr, vt[i].e_addr);
    if (vt[i].e_idok)
      chk($sformatf("%s[%0d].inst_rdata", tag, i), inst_if.rdata, vt[i].rdata);
    if (vt[i].e_ddok)
      chk($sformatf("%s[%0d].data_rdata", tag, i), data_if.rdata, vt[i].rdata);
  endtask

  initial begin
    logic grants[10];
    logic exp_grants[10];
    int   ng;
    int   pulses;

    //          ireq dreq aok dok rdata  mreq busy own iaok idok daok ddok addr
    // single inst read
    vt[0]  = mk(1, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0);
    vt[1]  = mk(1, 0, 0, 0, 0,    1, 1, 0, 0, 0, 0, 0, IADDR);
    vt[2]  = mk(1, 0, 1, 0, 0,    1, 1, 0, 1, 0, 0, 0, IADDR);
    vt[3]  = mk(0, 0, 0, 0, 0,    0, 1, 0, 0, 0, 0, 0, 0);
    vt[4]  = mk(0, 0, 0, 1, RD1,  0, 1, 0, 0, 1, 0, 0, 0);
    vt[5]  = mk(0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0);
    // simultaneous requests: data first, inst after one idle bubble
    vt[6]  = mk(1, 1, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0);
    vt[7]  = mk(1, 1, 1, 0, 0,    1, 1, 1, 0, 0, 1, 0, DADDR);
    vt[8]  = mk(1, 0, 0, 1, RD2,  0, 1, 1, 0, 0, 0, 1, 0);
    vt[9]  = mk(1, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0);
    vt[10] = mk(1, 0, 1, 0, 0,    1, 1, 0, 1, 0, 0, 0, IADDR);
    vt[11] = mk(0, 0, 0, 1, RD1,  0, 1, 0, 0, 1, 0, 0, 0);
    vt[12] = mk(0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0);
    // spurious mem_dataok in IDLE/ADDR and mem_addrok in DATA
    vt[13] = mk(0, 1, 0, 1, 0,    0, 0, 0, 0, 0, 0, 0, 0);
    vt[14] = mk(0, 1, 0, 1, 0,    1, 1, 1, 0, 0, 0, 0, DADDR);
    vt[15] = mk(0, 1, 1, 0, 0,    1, 1, 1, 0, 0, 1, 0, DADDR);
    vt[16] = mk(0, 0, 1, 0, 0,    0, 1, 1, 0, 0, 0, 0, 0);
    vt[17] = mk(0, 0, 0, 1, RD2,  0, 1, 1, 0, 0, 0, 1, 0);
    vt[18] = mk(0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0);

    inst_if.req = 0; inst_if.wr = 0; inst_if.size = 2'd2;
    inst_if.addr = IADDR; inst_if.wdata = 32'h1111_2222;
    data_if.req = 0; data_if.wr = 0; data_if.size = 2'd2;
    data_if.addr = DADDR; data_if.wdata = 32'h3333_4444;
    mem_if.addrok = 0; mem_if.dataok = 0; mem_if.rdata = 0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst.busy", 32'(busy_o), 0);
    chk("rst.owner", 32'(owner_o), 0);
    chk("rst.mem_req", 32'(mem_if.req), 0);
    chk("rst.mem_addr", mem_if.addr, 0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 19; i++) apply_vec(i, "vec");

    // starvation: both masters request continuously
    exp_grants = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    @(negedge clk);
    inst_if.req = 1; data_if.req = 1; mem_if.addrok = 1; mem_if.dataok = 1;
    ng = 0;
    for (int c = 0; c < 60 && ng < 10; c++) begin
      @(negedge clk);
      #1;
      if (mem_if.req) begin
        grants[ng] = owner_o;
        chk($sformatf("starve.addrok[%0d]", ng),
            32'(owner_o ? data_if.addrok : inst_if.addrok), 1);
        ng++;
      end
    end
    chk("starve.grant_count", 32'(ng), 10);
    for (int g = 0; g < ng; g++)
      chk($sformatf("starve.grant[%0d]", g), 32'(grants[g]), 32'(exp_grants[g]));
    @(negedge clk);
    inst_if.req = 0; data_if.req = 0;
    for (int c = 0; c < 10 && busy_o; c++) @(negedge clk);
    chk("starve.drain_idle", 32'(busy_o), 0);
    mem_if.addrok = 0; mem_if.dataok = 0;

    // byte data write
    @(negedge clk);
    data_if.req = 1; data_if.wr = 1; data_if.size = 2'd0;
    data_if.addr = 32'h8000_00A3; data_if.wdata = 32'h0000_00FF;
    @(negedge clk);
    #1;
    chk("wr.mem_req", 32'(mem_if.req), 1);
    chk("wr.owner", 32'(owner_o), 1);
    chk("wr.mem_wr", 32'(mem_if.wr), 1);
    chk("wr.mem_size", 32'(mem_if.size), 0);
    chk("wr.mem_addr", mem_if.addr, 32'h8000_00A3);
    chk("wr.mem_wdata", mem_if.wdata, 32'h0000_00FF);
    mem_if.addrok = 1;
    #1;
    chk("wr.data_addrok", 32'(data_if.addrok), 1);
    @(negedge clk);
    data_if.req = 0; mem_if.addrok = 0; mem_if.dataok = 1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin
        @(negedge clk);
        mem_if.dataok = 0;
      end else if (c > 1) begin
        @(negedge clk);
      end
      #1;
      pulses += int'(data_if.dataok);
    end
    chk("wr.dataok_pulses", 32'(pulses), 1);
    data_if.wr = 0; data_if.size = 2'd2; data_if.addr = DADDR; data_if.wdata = 32'h3333_4444;

    // reset asserted during DATA
    @(negedge clk);
    inst_if.req = 1;
    @(negedge clk);
    mem_if.addrok = 1;
    @(negedge clk);
    inst_if.req = 0; mem_if.addrok = 0;
    #1;
    chk("rstmid.in_data", 32'(busy_o), 1);
    resetn = 1'b0;
    #1;
    chk("rstmid.busy", 32'(busy_o), 0);
    chk("rstmid.mem_req", 32'(mem_if.req), 0);
    chk("rstmid.mem_wr", 32'(mem_if.wr), 0);
    chk("rstmid.mem_size", 32'(mem_if.size), 0);
    chk("rstmid.mem_addr", mem_if.addr, 0);
    chk("rstmid.mem_wdata", mem_if.wdata, 0);
    chk("rstmid.owner", 32'(owner_o), 0);
    @(negedge clk);
    resetn = 1'b1;
    mem_if.dataok = 1;
    #1;
    chk("rstmid.late_inst_dataok", 32'(inst_if.dataok), 0);
    chk("rstmid.late_data_dataok", 32'(data_if.dataok), 0);
    @(negedge clk);
    mem_if.dataok = 0;
    for (int i = 0; i < 6; i++) apply_vec(i, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
